// File: rtl/decoder_2_to_4_reg.sv
// Registered 2-to-4 one-hot decoder that shows each word for HOLD cycles, then offers it with a valid/ready handshake.
// Optional macro DEC_ACC_CNT_EN adds the acc_cnt port: a saturating count of accepted codes.
module decoder_2_to_4_reg #(
    parameter int unsigned HOLD  = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [1:0]       code,
    output logic             in_ready,
    output logic [3:0]       y,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DEC_ACC_CNT_EN
    ,
    output logic [CNT_W-1:0] acc_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for a code; in_ready follows en, y cleared
    // SHOW  | decoded word visible, hold counter running down
    // OFFER | word offered on out_valid until out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        OFFER = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LD = 8'(HOLD - 1);

    state_t      state_q, state_d;
    logic [7:0]  hold_q,  hold_d;
    logic [1:0]  code_q,  code_d;
    logic [3:0]  y_q,     y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= 8'd0;
            code_q  <= 2'd0;
            y_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            code_q  <= code_d;
            y_q     <= y_d;
        end
    end

    // y is rebuilt from the latched code each cycle, so it can only be zero or one-hot
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                y_d = 4'd0;
                if (in_valid && en) begin
                    code_d  = code;
                    y_d     = 4'b0001 << code;
                    hold_d  = HOLD_LD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                y_d = 4'b0001 << code_q;
                if (hold_q == 8'd0) begin
                    state_d = OFFER;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            OFFER: begin
                y_d = 4'b0001 << code_q;
                if (out_ready) begin
                    y_d     = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                y_d     = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // gating with rst_n keeps in_ready low for the whole reset pulse
    assign in_ready  = rst_n && en && (state_q == IDLE);
    assign out_valid = (state_q == OFFER);
    assign y         = y_q;

`ifdef DEC_ACC_CNT_EN
    logic acc_inc;
    assign acc_inc = (state_q == IDLE) && in_valid && en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (acc_inc && (acc_cnt != {CNT_W{1'b1}})) begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_2_to_4_reg.sv
// Self-checking bench for decoder_2_to_4_reg (HOLD=4, CNT_W=2): scoreboard of expected words checked at each handshake.
module tb_decoder_2_to_4_reg;

    localparam int unsigned HOLD  = 4;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             in_valid;
    logic [1:0]       code;
    logic             in_ready;
    logic [3:0]       y;
    logic             out_valid;
    logic             out_ready;
`ifdef DEC_ACC_CNT_EN
    logic [CNT_W-1:0] acc_cnt;
`endif

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [3:0]       sb[$];
    int               cyc = 0;

    decoder_2_to_4_reg #(.HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .code      (code),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEC_ACC_CNT_EN
        ,
        .acc_cnt   (acc_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // handshake monitor: the word taken must match the oldest accepted code
    always @(posedge clk) begin
        cyc++;
        if (rst_n) begin
            chk("y_onehot", ($countones(y) <= 1), 1);
            if (out_valid && out_ready) begin
                chk("sb_nonempty", (sb.size() > 0), 1);
                if (sb.size() > 0) chk("sb_y", y, sb.pop_front());
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_out_valid(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    // present one code at a negedge where in_ready is high; it is taken at the next posedge
    task automatic send(input logic [1:0] c);
        wait_ready("send");
        code     = c;
        in_valid = 1'b1;
        sb.push_back(4'b0001 << c);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        int last_acc;
        rst_n     = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        code      = 2'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_y", y, 4'd0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        en    = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // basic decode with hold-length measurement
        send(2'd2);
        chk("basic_y", y, 4'b0100);
        chk("basic_ov_low", out_valid, 0);
        wait_out_valid("basic", n);
        chk("basic_hold_len", n, HOLD);
        chk("basic_y_offer", y, 4'b0100);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("basic_y_clr", y, 4'd0);
        chk("basic_in_ready", in_ready, 1);
        chk("basic_ov_clr", out_valid, 0);

        // all four codes back to back, out_ready tied high
        out_ready = 1'b1;
        last_acc  = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ready("exh");
            if (k > 0) chk("exh_period", cyc - last_acc, HOLD + 2);
            last_acc = cyc;
            code     = 2'(k);
            in_valid = 1'b1;
            sb.push_back(4'b0001 << k);
            @(negedge clk);
            in_valid = 1'b0;
            chk("exh_y", y, 4'b0001 << k);
        end
        wait_ready("exh_drain");
        out_ready = 1'b0;
        chk("exh_sb_empty", sb.size(), 0);

        // backpressure: word stays put, new codes ignored
        send(2'd1);
        wait_out_valid("bp", n);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            code     = 2'd3;
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_y", y, 4'b0010);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_y_clr", y, 4'd0);
        chk("bp_sb_empty", sb.size(), 0);

        // enable: blocked in IDLE, ignored once running
        en       = 1'b0;
        in_valid = 1'b1;
        code     = 2'd1;
        repeat (3) begin
            @(negedge clk);
            chk("en_y", y, 4'd0);
            chk("en_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        en       = 1'b1;
        send(2'd0);
        en = 1'b0;
        wait_out_valid("en_show", n);
        chk("en_offer_reached", out_valid, 1);
        chk("en_offer_y", y, 4'b0001);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        en        = 1'b1;

        // asynchronous reset in the middle of SHOW
        send(2'd3);
        chk("rstm_y_before", y, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_y", y, 4'd0);
        chk("rstm_out_valid", out_valid, 0);
        chk("rstm_in_ready", in_ready, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstm_in_ready_rel", in_ready, 1);
        @(negedge clk);
        chk("rstm_no_offer", out_valid, 0);

        // five accepted codes; counter (when present) saturates at 3
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            send(2'(k % 4));
`ifdef DEC_ACC_CNT_EN
            chk("acc_cnt_step", acc_cnt, (k + 1 > 3) ? 3 : k + 1);
`endif
        end
        wait_ready("cnt_drain");
        out_ready = 1'b0;
        chk("cnt_sb_empty", sb.size(), 0);
`ifdef DEC_ACC_CNT_EN
        chk("acc_cnt_sat", acc_cnt, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/decoder_2_to_4_reg.md
DECODER_2_TO_4_REG -- requirements
Module: decoder_2_to_4_reg

Interface
REQ-001 The block SHALL have parameter HOLD, default 4, giving the number of cycles a decoded word is shown before it is offered; legal range 1..255.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the accepted-code counter.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit: the reset, asynchronous and active-low.
REQ-005 Port en SHALL be an input, 1 bit: the decode enable.
REQ-006 Port in_valid SHALL be an input, 1 bit: a code is presented.
REQ-007 Port code SHALL be an input, 2 bits: the binary code to decode (e1:e0 order, code[1]=MSB).
REQ-008 Port in_ready SHALL be an output, 1 bit: the block can accept a code.
REQ-009 Port y SHALL be an output, 4 bits: the registered one-hot decode, where y[k]=1 for code k.
REQ-010 Port out_valid SHALL be an output, 1 bit: the decoded word is complete and offered.
REQ-011 Port out_ready SHALL be an input, 1 bit: the consumer takes the offered word.
REQ-012 Port acc_cnt SHALL be an output, CNT_W bits: the number of accepted codes; this port is present only with DEC_ACC_CNT_EN.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHOW and OFFER, encoded in 2 bits.
REQ-014 In IDLE: in_ready=en, y=0 and out_valid=0.
REQ-015 In IDLE, in_valid&&en SHALL accept the code: code is latched, y is set to its one-hot value, the hold counter is loaded with HOLD-1, and the next state is SHOW.
REQ-016 Latency SHALL be one cycle: y is valid on the cycle after acceptance.
REQ-017 In SHOW: in_ready=0, y is held and out_valid=0; the hold counter decrements each cycle; when the counter is 0, the next state is OFFER.
REQ-018 y SHALL therefore be visible for exactly HOLD cycles before out_valid rises; with HOLD=1 the block spends exactly one cycle in SHOW.
REQ-019 In OFFER: out_valid=1, y is held and in_ready=0; out_ready SHALL complete the transfer, clear y to 0 and return the FSM to IDLE on the next cycle.
REQ-020 out_valid, once asserted, SHALL remain asserted with y stable until out_ready is sampled high.
REQ-021 in_valid while not in IDLE SHALL be ignored, with no state change and no latch.
REQ-022 en=0 SHALL only block acceptance in IDLE; deasserting en during SHOW or OFFER SHALL NOT abort the operation.
REQ-023 A code arriving on the cycle OFFER completes SHALL NOT be accepted (in_ready=0); it is accepted at the earliest one cycle later in IDLE.
REQ-024 y SHALL always be 0 or one-hot; it is never multi-hot.
REQ-025 Back-to-back operation SHALL achieve a minimum period of HOLD+2 cycles per code.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, y=0, out_valid=0, the hold counter to 0, the latched code to 0 and acc_cnt=0, independent of clk.
REQ-027 Reset asserted mid-SHOW or mid-OFFER SHALL abort the operation without a transfer.
REQ-028 After rst_n rises, in_ready SHALL equal en.

Configuration
REQ-029 With macro DEC_ACC_CNT_EN defined, acc_cnt SHALL increment by 1 on each acceptance and saturate at all-ones without wrapping.
REQ-030 Without DEC_ACC_CNT_EN, the acc_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (HOLD=4)
REQ-031 Reset: rst_n=0 asynchronously mid-SHOW -> y=0, out_valid=0 and in_ready=0 at once; after release with en=1 -> in_ready=1.
REQ-032 Basic decode: en=1 and in_valid with code=2'b10 for 1 cycle -> y=4'b0100 next cycle, out_valid=1 exactly 4 cycles after y rises; out_ready=1 -> y=0 and in_ready=1 next cycle.
REQ-033 Exhaustive codes: codes 0,1,2,3 in sequence with out_ready tied high -> y=0001, 0010, 0100, 1000; one code per 6 cycles; y is never multi-hot.
REQ-034 Backpressure: out_ready=0 for 10 cycles in OFFER -> out_valid and y stay stable; in_valid with code=3 during this time is ignored.
REQ-035 Enable: en=0 with in_valid and code=1 -> no acceptance and y=0; en dropped in SHOW -> OFFER is still reached.
REQ-036 Counter: with DEC_ACC_CNT_EN and CNT_W=2, 5 accepted codes -> acc_cnt=3 (saturated); without the macro, the port is absent and the other results are identical.
